power_stim_seq: RTL and testbench

- Sequencer that drives pseudo-random input vectors into an external small combinational cone (up to VEC_W inputs, 1 output), such as the 4-input/1-output power sub-circuits.
- Samples the cone response after a programmable settle time.
- Accumulates switching-activity statistics (input toggles, output toggles, output ones) used for power characterisation of rewritten sub-circuits.
- Sits between the experiment harness (start/done) and the sub-circuit under measurement.

---
 rtl/power_stim_seq.sv | 107 ++++++++++
 tb/tb_power_stim_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/power_stim_seq.sv
// power_stim_seq: LFSR stimulus sequencer with switching-activity counters; POWER_STIM_SEQ_TRACE_EN adds trace outputs
module power_stim_seq #(
  parameter int VEC_W = 4,
  parameter int CNT_W = 16,
  parameter int SETTLE = 1,
  parameter logic [VEC_W-1:0] TAPS = VEC_W'(4'b1100)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  input  logic [VEC_W-1:0] seed,
  output logic [VEC_W-1:0] stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] in_toggles,
  output logic [CNT_W-1:0] out_toggles,
  output logic [CNT_W-1:0] ones_cnt
`ifdef POWER_STIM_SEQ_TRACE_EN
  ,
  output logic             trace_valid,
  output logic [VEC_W-1:0] trace_vec,
  output logic             trace_resp
`endif
);
  localparam int WW = $clog2(SETTLE + 2);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
  state_t state;
  logic [WW-1:0] wt;
  logic [CNT_W-1:0] rem;
  logic first, prev;
  logic [VEC_W-1:0] nxt, seed_fix;
  assign nxt = {stim[VEC_W-2:0], ^(stim & TAPS)};
  assign seed_fix = (seed == '0) ? '1 : seed;
  function automatic logic [CNT_W-1:0] pop(input logic [VEC_W-1:0] v);
    pop = '0;
    for (int i = 0; i < VEC_W; i++) pop = pop + CNT_W'(v[i]);
  endfunction
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
`ifdef POWER_STIM_SEQ_TRACE_EN
  assign trace_valid = (state == ST_SAMPLE);
  assign trace_vec = trace_valid ? stim : '0;
  assign trace_resp = trace_valid & resp;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      stim <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      in_toggles <= '0;
      out_toggles <= '0;
      ones_cnt <= '0;
      rem <= '0;
      wt <= '0;
      first <= 1'b0;
      prev <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          in_toggles <= '0;
          out_toggles <= '0;
          ones_cnt <= '0;
          if (num_vecs != '0) begin
            stim <= seed_fix;
            rem <= num_vecs;
            wt <= WW'(SETTLE);
            first <= 1'b1;
            busy <= 1'b1;
            state <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
          end else begin
            done <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_SETTLE: begin
          wt <= wt - 1'b1;
          if (wt == WW'(1)) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          ones_cnt <= sat_add(ones_cnt, CNT_W'(resp));
          if (!first && resp != prev) out_toggles <= sat_add(out_toggles, CNT_W'(1));
          first <= 1'b0;
          prev <= resp;
          rem <= rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= ST_DONE;
          end else begin
            stim <= nxt;
            in_toggles <= sat_add(in_toggles, pop(stim ^ nxt));
            wt <= WW'(SETTLE);
            state <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_power_stim_seq.sv
// tb_power_stim_seq: scoreboard bench for power_stim_seq (default build and SETTLE=0/CNT_W=4 build)
module tb_power_stim_seq;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start_a = 1'b0, start_b = 1'b0, mode = 1'b0, sel = 1'b0;
  logic [15:0] nv_a = '0;
  logic [3:0] nv_b = '0, seed_a = '0, seed_b = '0;
  logic [3:0] stim_a, stim_b;
  logic busy_a, busy_b, done_a, done_b;
  logic [15:0] it_a, ot_a, oc_a;
  logic [3:0] it_b, ot_b, oc_b;
  logic resp_a, resp_b;
  assign resp_a = mode & stim_a[0];
  assign resp_b = mode & stim_b[0];
  power_stim_seq ua (
    .clk(clk), .rst(rst), .start(start_a), .num_vecs(nv_a), .seed(seed_a),
    .stim(stim_a), .resp(resp_a), .busy(busy_a), .done(done_a),
    .in_toggles(it_a), .out_toggles(ot_a), .ones_cnt(oc_a)
  );
  power_stim_seq #(.CNT_W(4), .SETTLE(0)) ub (
    .clk(clk), .rst(rst), .start(start_b), .num_vecs(nv_b), .seed(seed_b),
    .stim(stim_b), .resp(resp_b), .busy(busy_b), .done(done_b),
    .in_toggles(it_b), .out_toggles(ot_b), .ones_cnt(oc_b)
  );
  logic [3:0] stim_v;
  logic busy_v, done_v;
  logic [15:0] it_v, ot_v, oc_v;
  assign stim_v = sel ? stim_b : stim_a;
  assign busy_v = sel ? busy_b : busy_a;
  assign done_v = sel ? done_b : done_a;
  assign it_v = sel ? {12'b0, it_b} : it_a;
  assign ot_v = sel ? {12'b0, ot_b} : ot_a;
  assign oc_v = sel ? {12'b0, oc_b} : oc_a;
  int checks = 0, errors = 0;
  int stim_q[$], cnt_q[$];
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model(input logic [3:0] sd, input int n, input bit m, input int cmax);
    logic [3:0] v, p;
    int it, ot, oc;
    bit r, pr;
    it = 0; ot = 0; oc = 0; pr = 1'b0;
    v = (sd == 4'd0) ? 4'hf : sd;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        p = v;
        v = {v[2:0], v[3] ^ v[2]};
        it = (it + $countones(p ^ v) > cmax) ? cmax : it + $countones(p ^ v);
      end
      stim_q.push_back(int'(v));
      r = m & v[0];
      if (r && oc < cmax) oc++;
      if (k > 0 && r != pr && ot < cmax) ot++;
      pr = r;
    end
    cnt_q.push_back(it);
    cnt_q.push_back(ot);
    cnt_q.push_back(oc);
  endtask
  task automatic run(input bit s, input logic [3:0] sd, input int n, input bit m);
    int st, bc, cyc;
    st = s ? 0 : 1;
    model(sd, n, m, s ? 15 : 65535);
    @(negedge clk);
    sel = s;
    mode = m;
    if (s) begin start_b = 1'b1; nv_b = 4'(n); seed_b = sd; end
    else begin start_a = 1'b1; nv_a = 16'(n); seed_a = sd; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    bc = 0;
    cyc = 0;
    while (!done_v && cyc < n * (st + 1) + 8) begin
      if (busy_v) begin
        bc++;
        if (bc % (st + 1) == 0 && stim_q.size() > 0) chk("stim", int'(stim_v), stim_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    chk("done", int'(done_v), 1);
    chk("busy_len", bc, n * (st + 1));
    chk("busy_at_done", int'(busy_v), 0);
    chk("in_toggles", int'(it_v), cnt_q.pop_front());
    chk("out_toggles", int'(ot_v), cnt_q.pop_front());
    chk("ones_cnt", int'(oc_v), cnt_q.pop_front());
    chk("vecs_left", stim_q.size(), 0);
    stim_q.delete();
    @(negedge clk);
    chk("done_pulse", int'(done_v), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stim", int'(stim_a), 0);
    chk("rst_busy", int'(busy_a | busy_b), 0);
    chk("rst_done", int'(done_a | done_b), 0);
    chk("rst_cnt", int'(it_a | ot_a | oc_a), 0);
    rst = 1'b0;
    run(1'b0, 4'b0001, 4, 1'b0);
    run(1'b0, 4'b0001, 4, 1'b1);
    run(1'b0, 4'b0001, 0, 1'b1);
    run(1'b1, 4'b0000, 2, 1'b0);
    run(1'b1, 4'b0001, 15, 1'b0);
    run(1'b1, 4'b0001, 15, 1'b1);
    @(negedge clk);
    sel = 1'b0;
    mode = 1'b0;
    start_a = 1'b1; nv_a = 16'd10; seed_a = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    chk("mid_busy", int'(busy_a), 1);
    chk("mid_stim", int'(stim_a), 2);
    chk("mid_in_toggles", int'(it_a), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_stim", int'(stim_a), 0);
    chk("mrst_busy", int'(busy_a), 0);
    chk("mrst_done", int'(done_a), 0);
    chk("mrst_cnt", int'(it_a | ot_a | oc_a), 0);
    rst = 1'b0;
    run(1'b0, 4'b0101, 6, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
